// File: rtl/mem_bus_responder_pkg.sv
// Address map and STATUS layout shared by the word-bus responder and its bench.
// Pure constants; no logic.
package mem_bus_responder_pkg;

  localparam int ADDR_TXDATA  = 'hFF00;
  localparam int ADDR_STATUS  = 'hFF01;
  localparam int ADDR_CYCLES  = 'hFF02;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;

  localparam int CYCLE_BITS   = 32;

endpackage

// File: rtl/mem_bus_responder_sync_fifo.sv
// Synchronous FIFO, show-ahead head (zero-latency dout); push ignored when full, pop ignored when empty.
// Backpressure is the caller's job: full/empty/count are exported and reflect pre-edge state.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      slots [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Word-bus memory responder: RAM, console TX FIFO and cycle counter; reads are combinational.
// TX side is valid/ready; pushes into a full FIFO are dropped and latch a sticky overflow flag.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int BITS_DATA       = 32,
  parameter int BITS_ADDR       = 16,
  parameter int RAM_ADDR_BITS   = 12,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITS_ADDR-1:0] MAR,
  input  logic [BITS_DATA-1:0] MBR_W,
  input  logic                 write,
  output logic [BITS_DATA-1:0] MBR_R,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);

  logic [BITS_DATA-1:0]    ram [2 ** RAM_ADDR_BITS];
  logic [CYCLE_BITS-1:0]   cycles;
  logic                    overflow;
  logic                    prev_strobe;

  logic                    sel_ram;
  logic                    sel_txdata;
  logic                    sel_status;
  logic                    sel_cycles;
  logic                    txdata_strobe;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  logic [BITS_DATA-1:0]    status;

  assign sel_ram    = (MAR[BITS_ADDR-1:RAM_ADDR_BITS] == '0);
  assign sel_txdata = (MAR == BITS_ADDR'(ADDR_TXDATA));
  assign sel_status = (MAR == BITS_ADDR'(ADDR_STATUS));
  assign sel_cycles = (MAR == BITS_ADDR'(ADDR_CYCLES));

  // Only the first cycle of a held TXDATA write pushes.
  assign txdata_strobe = write && sel_txdata;
  assign push          = txdata_strobe && !prev_strobe;
  assign pop           = tx_valid && tx_ready;
  assign tx_valid      = !fifo_empty;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (MBR_W[7:0]),
    .pop   (pop),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (write && sel_ram) ram[MAR[RAM_ADDR_BITS-1:0]] <= MBR_W;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_strobe <= 1'b0;
      overflow    <= 1'b0;
      cycles      <= '0;
    end else begin
      prev_strobe <= txdata_strobe;
      if (push && fifo_full) begin
        overflow <= 1'b1;
      end else if (write && sel_status && MBR_W[ST_OVF]) begin
        overflow <= 1'b0;
      end
      cycles <= (write && sel_cycles) ? CYCLE_BITS'(MBR_W) : cycles + 1'b1;
    end
  end

  always_comb begin
    status = '0;
    status[ST_COUNT_LSB +: FIFO_DEPTH_LOG2 + 1] = fifo_count;
    status[ST_OVF]   = overflow;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
  end

  // TXDATA and unmapped addresses fall through to zero.
  always_comb begin
    MBR_R = '0;
    if (sel_ram) begin
      MBR_R = ram[MAR[RAM_ADDR_BITS-1:0]];
    end else if (sel_status) begin
      MBR_R = status;
    end else if (sel_cycles) begin
      MBR_R = BITS_DATA'(cycles);
    end
  end

endmodule
